// File: rtl/fetch_queue.sv
// Instruction fetch/prefetch queue: sequential word fetch into a small FWFT FIFO with redirect flush.
// Optional FETCH_STALL_CNT_EN adds a saturating consumer-stall counter output.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic            imem_rd,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] fetch_pc,
    output logic            misalign
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [PC_W-1:0] pc_mem_q    [DEPTH];

    logic room_c;
    logic issue_c;
    logic push_c;
    logic pop_c;
    logic valid_c;

    // Slot reservation counts the in-flight request so a response never meets a full queue
    always_comb begin
        valid_c = (count_q != '0);
        room_c  = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
        issue_c = rst & fetch_en & ~redirect & room_c;
        push_c  = inflight_q & ~redirect;
        pop_c   = valid_c & instr_ready & ~redirect;
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        req_pc_d   = req_pc_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = 1'b0;
        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
            misalign_d = |redirect_pc[1:0];
        end else begin
            inflight_d = issue_c;
            if (issue_c) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_W'(4);
            end
            if (push_c) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop_c) begin
                head_d = head_q + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Queue storage needs no reset: entries are only observed while valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            instr_mem_q[tail_q] <= imem_data;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

    assign imem_rd     = issue_c;
    assign imem_addr   = fetch_pc_q[31:0];
    assign fetch_pc    = fetch_pc_q;
    assign misalign    = misalign_q;
    assign instr_valid = valid_c;
    assign instr       = valid_c ? instr_mem_q[head_q] : 32'h0;
    assign instr_pc    = valid_c ? pc_mem_q[head_q] : '0;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles the consumer waits on an empty queue; saturates, ignores redirect
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (instr_ready && !valid_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, backpressure, redirect, misalign, reset, wrap, drain.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_pc;
    logic        misalign;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int vectors;
    int miscompares;

    fetch_queue #(.DEPTH(4), .PC_W(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc),
        .misalign    (misalign)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: mem[k] = 0x1000 + k
    always @(posedge clk) begin
        if (imem_rd) imem_data <= 32'h1000 + (imem_addr >> 2);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        imem_data   = 32'h0;
        rst         = 1'b0;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #3;
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_rd", 64'(imem_rd), 64'h0);
        check("rst_fpc", fetch_pc, 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_ipc", instr_pc, 64'h0);
        check("rst_misalign", 64'(misalign), 64'h0);

        // Streaming with consumer always ready
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s1_rd0", 64'(imem_rd), 64'h1);
        check("s1_addr0", 64'(imem_addr), 64'h0);
        tick();
        check("s1_addr1", 64'(imem_addr), 64'h4);
        check("s1_valid1", 64'(instr_valid), 64'h0);
        tick();
        check("s1_valid2", 64'(instr_valid), 64'h1);
        check("s1_instr2", 64'(instr), 64'h1000);
        check("s1_ipc2", instr_pc, 64'h0);
        check("s1_addr2", 64'(imem_addr), 64'h8);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("s1_stream_pc", instr_pc, 64'(4 * i));
            check("s1_stream_instr", 64'(instr), 64'(32'h1000 + i));
        end

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("s5_valid", 64'(instr_valid), 64'h0);
        check("s5_rd", 64'(imem_rd), 64'h0);
        check("s5_fpc", fetch_pc, 64'h0);

        // Backpressure: queue fills, fetch stops
        instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s2_rd0", 64'(imem_rd), 64'h1);
        check("s2_addr0", 64'(imem_addr), 64'h0);
        repeat (5) tick();
        check("s2_full_valid", 64'(instr_valid), 64'h1);
        check("s2_full_rd", 64'(imem_rd), 64'h0);
        check("s2_full_fpc", fetch_pc, 64'h10);
        check("s2_full_ipc", instr_pc, 64'h0);
        tick();
        check("s2_hold_rd", 64'(imem_rd), 64'h0);
        instr_ready = 1'b1;
        #1;
        check("s2_rel_ipc0", instr_pc, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("s2_rel_ipc", instr_pc, 64'(4 * i));
        end

        // Redirect with slots fully reserved (3 entries + 1 in flight)
        instr_ready = 1'b0;
        tick();
        check("s3_pre_ipc", instr_pc, 64'h10);
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        #1;
        check("s3_redir_rd", 64'(imem_rd), 64'h0);
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("s3_valid_n1", 64'(instr_valid), 64'h0);
        check("s3_addr_n1", 64'(imem_addr), 64'h100);
        check("s3_rd_n1", 64'(imem_rd), 64'h1);
        check("s3_misalign", 64'(misalign), 64'h0);
        tick();
        check("s3_valid_n2", 64'(instr_valid), 64'h0);
        tick();
        check("s3_valid_n3", 64'(instr_valid), 64'h1);
        check("s3_ipc_n3", instr_pc, 64'h100);
        check("s3_instr_n3", 64'(instr), 64'h1040);
        tick();
        check("s3_ipc_n4", instr_pc, 64'h104);
        check("s3_instr_n4", 64'(instr), 64'h1041);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 64'h102;
        #1;
        check("s4_redir_rd", 64'(imem_rd), 64'h0);
        tick();
        redirect = 1'b0;
        #1;
        check("s4_misalign_hi", 64'(misalign), 64'h1);
        check("s4_valid", 64'(instr_valid), 64'h0);
        check("s4_fpc", fetch_pc, 64'h100);
        check("s4_rd", 64'(imem_rd), 64'h1);
        tick();
        check("s4_misalign_lo", 64'(misalign), 64'h0);
        tick();
        check("s4_ipc", instr_pc, 64'h100);

        // Back-to-back misaligned redirects: last wins, one pulse each
        redirect    = 1'b1;
        redirect_pc = 64'h203;
        tick();
        redirect_pc = 64'h301;
        check("bb_misalign1", 64'(misalign), 64'h1);
        check("bb_fpc1", fetch_pc, 64'h200);
        check("bb_valid1", 64'(instr_valid), 64'h0);
        tick();
        redirect = 1'b0;
        check("bb_misalign2", 64'(misalign), 64'h1);
        check("bb_fpc2", fetch_pc, 64'h300);
        tick();
        check("bb_misalign3", 64'(misalign), 64'h0);
        tick();
        check("bb_ipc", instr_pc, 64'h300);
        check("bb_instr", 64'(instr), 64'h10C0);

        // fetch_pc wraps modulo 2^64
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        check("wrap_fpc0", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
        check("wrap_rd0", 64'(imem_rd), 64'h1);
        tick();
        check("wrap_fpc1", fetch_pc, 64'h0);

        // fetch_en low: outstanding response still captured, no new requests
        fetch_en = 1'b0;
        #1;
        check("fe0_rd", 64'(imem_rd), 64'h0);
        tick();
        check("fe0_valid", 64'(instr_valid), 64'h1);
        check("fe0_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("fe0_instr", 64'(instr), 64'h4000_0FFF);
        tick();
        check("fe0_fpc", fetch_pc, 64'h0);
        check("fe0_rd2", 64'(imem_rd), 64'h0);

`ifdef FETCH_STALL_CNT_EN
        // Stall counter: 10 empty-and-ready cycles, then a redirect leaves it untouched
        #2;
        rst = 1'b0;
        #1;
        check("sc_rst", 64'(stall_cnt), 64'h0);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) tick();
        check("sc_ten", 64'(stall_cnt), 64'd10);
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect = 1'b0;
        tick();
        check("sc_redir", 64'(stall_cnt), 64'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch and prefetch stage directly upstream of the instruction register.
- Generates sequential word addresses into the 32-bit synchronous-read instruction memory and buffers the returned words in a small FIFO.
- Presents each word with its PC to the datapath through a valid/ready handshake; the controller's instruction-register load is "ready".
- Branch/jump redirect from the datapath flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 64'h0, fetch address after reset
PC_W, 64, width of PC values

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
fetch_en  in  1  permits new memory requests
imem_rd  out  1  read request to instruction memory
imem_addr  out  32  request address = fetch_pc[31:0]
imem_data  in  32  read data, valid exactly 1 cycle after imem_rd
instr  out  32  head-of-queue instruction
instr_pc  out  PC_W  PC of head instruction
instr_valid  out  1  queue non-empty
instr_ready  in  1  consumer accepts head this cycle
redirect  in  1  flush and restart fetch
redirect_pc  in  PC_W  restart target
fetch_pc  out  PC_W  next address to be requested
misalign  out  1  one-cycle pulse: redirect target not word-aligned

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, queue empty, in-flight flag 0, instr_valid=0, instr=0, instr_pc=0, imem_rd=0, misalign=0. Values apply immediately, with no clock edge.
- Issue condition (combinational): imem_rd = fetch_en & ~redirect & (count + inflight < DEPTH).
  - Use current-cycle count; a same-cycle pop does not free a slot until the next cycle.
  - On issue: capture req_pc=fetch_pc, set inflight=1, and fetch_pc += 4 at the edge. fetch_pc wraps modulo 2^PC_W.
- Response: in the cycle after issue, imem_data and req_pc are written at the tail and inflight clears, unless a redirect is active that cycle.
  - Slot reservation guarantees a response never meets a full queue.
- Output (first-word fall-through): instr and instr_pc show the head entry; both are 0 when empty. instr_valid = (count != 0).
- Pop: occurs when instr_valid & instr_ready. The head advances and pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves count unchanged.
- Throughput: with fetch_en=1 and instr_ready held 1, one instruction per cycle is sustained after a 2-cycle initial latency.
- Redirect (priority over all else) at edge n:
  - count, head and tail := 0; inflight := 0.
  - Any response arriving in cycle n is discarded, and no request issues in cycle n.
  - fetch_pc := {redirect_pc[PC_W-1:2], 2'b00}.
  - misalign := |redirect_pc[1:0] for one cycle.
  - A pop in the same cycle is irrelevant because the entry is flushed.
  - First request at the target issues in cycle n+1; instr_valid rises in cycle n+2 at the earliest.
- fetch_en=0: no new requests. An outstanding response is still captured, and the queue drains normally.
- Back-to-back redirects: the last one wins, and each misaligned target produces its own pulse.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined: adds output stall_cnt, 32 bits.
  - Increments every cycle that instr_ready=1 and instr_valid=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst; unaffected by redirect.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

Test Plan:
1. Reset release with RESET_PC=0, mem[k]=32'h1000+k, instr_ready=1 -> imem_addr 0,4,8... on consecutive cycles; first instr_valid 2 cycles after release with instr=32'h1000, instr_pc=0; then instr_pc 4,8,12 each cycle with no gaps.
2. Hold instr_ready=0 -> exactly 4 entries captured, imem_rd low thereafter, fetch_pc=16; on release, instr_pc 0,4,8,12,16 in order with no duplicates or losses.
3. Full queue plus request in flight, redirect=1 with redirect_pc=0x100 -> next cycle instr_valid=0 and imem_addr=0x100; two cycles later instr_pc=0x100; the stale in-flight word is never presented.
4. redirect_pc=0x102 -> misalign high for exactly one cycle, fetch restarts at 0x100.
5. Assert rst mid-stream between clock edges -> instr_valid=0, imem_rd=0, fetch_pc=RESET_PC immediately; after release, behaviour matches scenario 1.
6. With FETCH_STALL_CNT_EN defined: hold fetch_en=0 and instr_ready=1 for 10 cycles from empty -> stall_cnt=10; a redirect leaves it at 10.
